// File: rtl/fcmp_pipe.sv
// Pipelined floating-point compare unit: feq/flt/fle/fmin/fmax with a
// global-stall valid/ready pipeline of STAGES register stages.
module fcmp_pipe #(
  parameter int EW     = 8,
  parameter int MW     = 23,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y
);

  localparam int W = 1 + EW + MW;

  // Unsigned ordering key; zero exponent flushes to +0 regardless of sign.
  function automatic logic [W-1:0] key(input logic [W-1:0] x);
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    {s, e, m} = x;
    if (e == '0)
      key = {1'b1, {(W-1){1'b0}}};
    else if (!s)
      key = {1'b1, e, m};
    else
      key = {1'b0, ~e, ~m};
  endfunction

  logic         advance;
  logic [W-1:0] fk1, fk2, fx1, fx2;
  logic [2:0]   fop;
  logic         fv;
  logic [W-1:0] y_next;
  logic         lt, eq, gt;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  if (STAGES == 1) begin : g_comb
    assign fk1 = key(x1);
    assign fk2 = key(x2);
    assign fx1 = x1;
    assign fx2 = x2;
    assign fop = op;
    assign fv  = in_valid;
  end else begin : g_pipe
    localparam int D = STAGES - 1;

    logic [W-1:0] k1_q [D];
    logic [W-1:0] k2_q [D];
    logic [W-1:0] x1_q [D];
    logic [W-1:0] x2_q [D];
    logic [2:0]   op_q [D];
    logic         v_q  [D];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < D; i++) begin
          k1_q[i] <= '0;
          k2_q[i] <= '0;
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          op_q[i] <= '0;
          v_q[i]  <= 1'b0;
        end
      end else if (advance) begin
        k1_q[0] <= key(x1);
        k2_q[0] <= key(x2);
        x1_q[0] <= x1;
        x2_q[0] <= x2;
        op_q[0] <= op;
        v_q[0]  <= in_valid;
        for (int i = 1; i < D; i++) begin
          k1_q[i] <= k1_q[i-1];
          k2_q[i] <= k2_q[i-1];
          x1_q[i] <= x1_q[i-1];
          x2_q[i] <= x2_q[i-1];
          op_q[i] <= op_q[i-1];
          v_q[i]  <= v_q[i-1];
        end
      end
    end

    assign fk1 = k1_q[D-1];
    assign fk2 = k2_q[D-1];
    assign fx1 = x1_q[D-1];
    assign fx2 = x2_q[D-1];
    assign fop = op_q[D-1];
    assign fv  = v_q[D-1];
  end

  assign lt = fk1 < fk2;
  assign eq = fk1 == fk2;
  assign gt = fk1 > fk2;

  // Ties in fmin/fmax keep x1 as presented, not its flushed form.
  always_comb begin
    y_next = '0;
    case (fop)
      3'b001:  y_next[0] = lt;
      3'b010:  y_next[0] = lt | eq;
      3'b011:  y_next    = gt ? fx2 : fx1;
      3'b100:  y_next    = lt ? fx2 : fx1;
      default: y_next[0] = eq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (advance) begin
      out_valid <= fv;
      y         <= y_next;
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Scoreboard bench for fcmp_pipe: four single-precision instances
// (STAGES 1..4) plus one double-precision STAGES=1 instance.
module tb_fcmp_pipe;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [NI];
  logic        ir   [NI];
  logic        ov   [NI];
  logic        ordy [NI];
  logic [2:0]  opv  [NI];
  logic [63:0] xa   [NI];
  logic [63:0] xb   [NI];
  logic [31:0] y32  [4];
  logic [63:0] yd;

  typedef struct {
    logic [63:0] y;
    int          acc;
    int          tag;
  } exp_t;

  exp_t sbq [NI][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_on = 1'b0;
  bit rdone  = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_s
    fcmp_pipe #(.EW(8), .MW(23), .STAGES(g + 1)) u (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .op(opv[g]),
      .x1(xa[g][31:0]), .x2(xb[g][31:0]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .y(y32[g])
    );
  end

  fcmp_pipe #(.EW(11), .MW(52), .STAGES(1)) u_d (
    .clk(clk), .rst(rst),
    .in_valid(iv[4]), .in_ready(ir[4]),
    .op(opv[4]),
    .x1(xa[4]), .x2(xb[4]),
    .out_valid(ov[4]), .out_ready(ordy[4]),
    .y(yd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int lat(int s);
    return (s < 4) ? s + 1 : 1;
  endfunction

  function automatic int ewof(int s);
    return (s < 4) ? 8 : 11;
  endfunction

  function automatic int mwof(int s);
    return (s < 4) ? 23 : 52;
  endfunction

  function automatic logic [63:0] yof(int s);
    return (s < 4) ? {32'b0, y32[s]} : yd;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Signed real-line position: flushed zero sits at 0, magnitudes grow outward.
  function automatic longint val(int s, logic [63:0] x);
    int ew = ewof(s);
    int mw = mwof(s);
    longint unsigned e, m;
    longint v;
    e = (x >> mw) & ((64'd1 << ew) - 1);
    m = x & ((64'd1 << mw) - 1);
    if (e == 0) return 0;
    v = longint'((e << mw) | m);
    return x[ew+mw] ? -v : v;
  endfunction

  function automatic logic [63:0] model(int s, logic [2:0] o,
                                        logic [63:0] a, logic [63:0] b);
    longint va = val(s, a);
    longint vb = val(s, b);
    case (o)
      3'd1:    return {63'b0, va < vb};
      3'd2:    return {63'b0, va <= vb};
      3'd3:    return (vb < va) ? b : a;
      3'd4:    return (vb > va) ? b : a;
      default: return {63'b0, va == vb};
    endcase
  endfunction

  function automatic logic [63:0] rnd(int s);
    int ew = ewof(s);
    int mw = mwof(s);
    logic [63:0] e, m, sg;
    case ($urandom % 5)
      0:       e = 64'd0;
      1:       e = (64'd1 << ew) - 1;
      2:       e = ((64'd1 << (ew - 1)) - 1) + 64'($urandom % 4) - 64'd2;
      default: e = 64'($urandom) & ((64'd1 << ew) - 1);
    endcase
    m = ($urandom % 4 == 0) ? 64'd0 :
        ({$urandom, $urandom} & ((64'd1 << mw) - 1));
    sg = 64'($urandom % 2);
    return (sg << (ew + mw)) | (e << mw) | m;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NI; s++) begin
        if (ov[s] && ordy[s]) begin
          if (sbq[s].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d unexpected output y %h", s, yof(s));
          end else begin
            exp_t e;
            e = sbq[s].pop_front();
            chk($sformatf("u%0d tag%0d y", s, e.tag), yof(s), e.y);
            if (lat_on)
              chk($sformatf("u%0d tag%0d latency", s, e.tag),
                  64'(cyc - e.acc), 64'(lat(s)));
          end
        end
      end
    end
  end

  task automatic send(int s, logic [2:0] o, logic [63:0] a, logic [63:0] b,
                      logic [63:0] e, int tag);
    int n = 0;
    bit done = 1'b0;
    iv[s]  = 1'b1;
    opv[s] = o;
    xa[s]  = a;
    xb[s]  = b;
    while (!done && n < 100) begin
      @(negedge clk);
      if (ir[s]) begin
        sbq[s].push_back(exp_t'{e, cyc, tag});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    iv[s] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL u%0d send tag%0d timeout", s, tag);
    end
  endtask

  task automatic drain();
    int n = 0;
    int left;
    left = 0;
    for (int s = 0; s < NI; s++) left += sbq[s].size();
    while (left != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      left = 0;
      for (int s = 0; s < NI; s++) left += sbq[s].size();
    end
    chk("drain pending", 64'(left), 64'd0);
  endtask

  initial begin
    for (int s = 0; s < NI; s++) begin
      iv[s]   = 1'b0;
      ordy[s] = 1'b1;
      opv[s]  = 3'd0;
      xa[s]   = '0;
      xb[s]   = '0;
    end
    #1;
    for (int s = 0; s < NI; s++) begin
      chk($sformatf("u%0d reset out_valid", s), 64'(ov[s]), 64'd0);
      chk($sformatf("u%0d reset y", s), yof(s), 64'd0);
      chk($sformatf("u%0d reset in_ready", s), 64'(ir[s]), 64'd1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed values with exact latency on every instance.
    lat_on = 1'b1;
    for (int s = 0; s < 4; s++) begin
      send(s, 3'd2, 64'h3F800000, 64'h40000000, 64'd1, 1);
      send(s, 3'd2, 64'h40000000, 64'h3F800000, 64'd0, 2);
    end
    send(1, 3'd0, 64'h80000001, 64'h00000000, 64'd1, 3);
    send(1, 3'd1, 64'h80000001, 64'h00000000, 64'd0, 4);
    send(1, 3'd2, 64'h80000001, 64'h00000000, 64'd1, 5);
    send(1, 3'd4, 64'h80000001, 64'h00000000, 64'h80000001, 6);
    send(1, 3'd1, 64'hC0000000, 64'hBF800000, 64'd1, 7);
    send(1, 3'd4, 64'hC0000000, 64'hBF800000, 64'hBF800000, 8);
    send(1, 3'd3, 64'hC0000000, 64'hBF800000, 64'hC0000000, 9);
    send(1, 3'd5, 64'h3F800000, 64'h3F800000, 64'd1, 10);
    send(4, 3'd2, 64'h3FF0000000000000, 64'h4000000000000000, 64'd1, 11);
    drain();

    // Back-pressure: four ops, stall the consumer 3 cycles once output shows.
    lat_on = 1'b0;
    fork
      begin
        send(1, 3'd4, 64'h3F800000, 64'd0, 64'h3F800000, 20);
        send(1, 3'd4, 64'h40000000, 64'd0, 64'h40000000, 21);
        send(1, 3'd4, 64'h40400000, 64'd0, 64'h40400000, 22);
        send(1, 3'd4, 64'h40800000, 64'd0, 64'h40800000, 23);
      end
      begin
        int n = 0;
        logic [31:0] yh;
        while (!ov[1] && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("bp out_valid seen", 64'(ov[1]), 64'd1);
        ordy[1] = 1'b0;
        yh = y32[1];
        repeat (3) begin
          @(negedge clk);
          chk("bp hold y", 64'(y32[1]), 64'(yh));
          chk("bp hold out_valid", 64'(ov[1]), 64'd1);
          chk("bp hold in_ready", 64'(ir[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        ordy[1] = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with ops in flight on the STAGES=3 instance.
    send(2, 3'd4, 64'h3F800000, 64'd0, 64'h3F800000, 30);
    send(2, 3'd4, 64'h40000000, 64'd0, 64'h40000000, 31);
    send(2, 3'd4, 64'h40400000, 64'd0, 64'h40400000, 32);
    send(2, 3'd4, 64'h40800000, 64'd0, 64'h40800000, 33);
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(ov[2]), 64'd0);
    chk("arst y", 64'(y32[2]), 64'd0);
    chk("arst in_ready", 64'(ir[2]), 64'd1);
    for (int s = 0; s < NI; s++) sbq[s].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post reset quiet", 64'(ov[2]), 64'd0);
    end
    @(posedge clk);
    #1;
    lat_on = 1'b1;
    send(2, 3'd2, 64'h3F800000, 64'h40000000, 64'd1, 40);
    drain();

    // Randomised sweep with random back-pressure and issue gaps.
    lat_on = 1'b0;
    for (int s = 0; s < NI; s++) begin
      rdone = 1'b0;
      fork
        begin
          for (int k = 0; k < 150; k++) begin
            logic [63:0] a, b;
            logic [2:0]  o;
            int          r;
            a = rnd(s);
            r = $urandom % 8;
            if (r < 2)
              b = a;
            else if (r < 3)
              b = a ^ (64'd1 << (ewof(s) + mwof(s)));
            else
              b = rnd(s);
            o = 3'($urandom % 8);
            if ($urandom % 3 == 0) begin
              @(posedge clk);
              #1;
            end
            send(s, o, a, b, model(s, o, a, b), 1000 + k);
          end
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            @(posedge clk);
            #1;
            ordy[s] = ($urandom % 4) != 0;
          end
          ordy[s] = 1'b1;
        end
      join
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
